// File: rtl/pb_pkg.sv
// ----------------------------------------------------------------------------
// pb_pkg -- shared definitions for the picture-buffer slice.
//
// Holds the default window/coordinate geometry, the coordinate typedefs and
// the capture FSM state enum. The capture controller, the picture buffer and
// the tracker all import this package so they agree on widths and encodings.
// ----------------------------------------------------------------------------
package pb_pkg;

    // Default window side in pixels (window is DefWin x DefWin).
    localparam int unsigned DefWin = 16;
    // Default width of camera pixel coordinates.
    localparam int unsigned DefCw  = 12;

    // Width of a row/column index inside the default window.
    localparam int unsigned DefRw  = $clog2(DefWin);

    // Camera coordinate and in-window buffer index for the default geometry.
    typedef logic [DefCw-1:0] coord_t;
    typedef logic [DefRw-1:0] pix_idx_t;

    // Capture controller states.
    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StCapture,
        StDone
    } cap_state_e;

    // Number of pixels in a complete window.
    function automatic int unsigned take_total(input int unsigned win);
        return win * win;
    endfunction

endpackage

// File: rtl/pb_capture_ctrl_if.sv
// ----------------------------------------------------------------------------
// pb_capture_ctrl_if -- camera/consumer bus of the capture controller.
//
// Inputs to the controller (driven by the master side):
//   i_frame_start  one-cycle pulse at the first pixel of a frame
//   i_pix_valid    pixel strobe, qualifies i_x/i_y
//   i_x, i_y       current camera pixel coordinates (CW bits)
//   i_win_x/_y     requested window top-left corner (CW bits)
//   i_arm          one-cycle capture request
//   i_buf_ack      consumer has read the completed buffer
// Outputs of the controller (driven by the slave side):
//   o_take         one-cycle capture strobe to the picture buffer
//   o_row, o_col   buffer address of the pixel taken ($clog2(WIN) bits)
//   o_buf_valid    buffer holds a complete window
//   o_busy         capture armed or in progress
//   o_overrun      one-cycle pulse when a capture is aborted incomplete
// ----------------------------------------------------------------------------
interface pb_capture_ctrl_if
    import pb_pkg::*;
#(
    parameter int unsigned WIN = DefWin,
    parameter int unsigned CW  = DefCw
);

    localparam int unsigned RW = $clog2(WIN);

    logic          i_frame_start;
    logic          i_pix_valid;
    logic [CW-1:0] i_x;
    logic [CW-1:0] i_y;
    logic [CW-1:0] i_win_x;
    logic [CW-1:0] i_win_y;
    logic          i_arm;
    logic          i_buf_ack;

    logic          o_take;
    logic [RW-1:0] o_row;
    logic [RW-1:0] o_col;
    logic          o_buf_valid;
    logic          o_busy;
    logic          o_overrun;

    // Camera / consumer side.
    modport master (
        output i_frame_start, i_pix_valid, i_x, i_y, i_win_x, i_win_y, i_arm, i_buf_ack,
        input  o_take, o_row, o_col, o_buf_valid, o_busy, o_overrun
    );

    // Capture controller side.
    modport slave (
        input  i_frame_start, i_pix_valid, i_x, i_y, i_win_x, i_win_y, i_arm, i_buf_ack,
        output o_take, o_row, o_col, o_buf_valid, o_busy, o_overrun
    );

endinterface

// File: rtl/pb_win_hit.sv
// ----------------------------------------------------------------------------
// pb_win_hit -- combinational in-window test and window-relative offsets.
//
// Ports:
//   i_pix_valid      pixel strobe
//   i_x, i_y         camera pixel coordinates (CW bits)
//   i_win_x/_y       window top-left corner (CW bits)
//   o_hit            pixel valid and inside the WIN x WIN window
//   o_row, o_col     i_y - i_win_y, i_x - i_win_x truncated to $clog2(WIN) bits
// ----------------------------------------------------------------------------
module pb_win_hit
    import pb_pkg::*;
#(
    parameter int unsigned WIN = DefWin,
    parameter int unsigned CW  = DefCw
) (
    input  logic                    i_pix_valid,
    input  logic [CW-1:0]           i_x,
    input  logic [CW-1:0]           i_y,
    input  logic [CW-1:0]           i_win_x,
    input  logic [CW-1:0]           i_win_y,
    output logic                    o_hit,
    output logic [$clog2(WIN)-1:0]  o_row,
    output logic [$clog2(WIN)-1:0]  o_col
);

    localparam int unsigned RW = $clog2(WIN);
    localparam int unsigned EW = CW + 1;

    // One extra bit so a window near the coordinate limit cannot wrap its
    // far edge back to small values.
    logic [EW-1:0] x_e, y_e;
    logic [EW-1:0] wx_lo, wy_lo;
    logic [EW-1:0] wx_hi, wy_hi;
    logic          x_in, y_in;

    always_comb begin
        x_e   = {1'b0, i_x};
        y_e   = {1'b0, i_y};
        wx_lo = {1'b0, i_win_x};
        wy_lo = {1'b0, i_win_y};
        wx_hi = wx_lo + EW'(WIN);
        wy_hi = wy_lo + EW'(WIN);

        x_in  = (x_e >= wx_lo) && (x_e < wx_hi);
        y_in  = (y_e >= wy_lo) && (y_e < wy_hi);
        o_hit = i_pix_valid && x_in && y_in;

        // Only meaningful when o_hit is set; the offset then fits in RW bits.
        o_row = RW'(i_y - i_win_y);
        o_col = RW'(i_x - i_win_x);
    end

endmodule

// File: rtl/pb_capture_ctrl.sv
// ----------------------------------------------------------------------------
// pb_capture_ctrl -- captures one WIN x WIN window of a camera frame.
//
// After i_arm in IDLE the requested corner is latched and the controller
// waits for the next frame start. During capture every in-window pixel
// produces a registered o_take with its buffer row/column. The WIN*WIN-th
// take completes the buffer (o_buf_valid) until the consumer acknowledges.
// A new frame start before completion pulses o_overrun and restarts the
// capture on that frame.
//
// Ports:
//   i_clk   sole clock, rising edge
//   i_rst   synchronous active-high reset
//   bus     pb_capture_ctrl_if.slave (camera inputs, buffer/status outputs)
// ----------------------------------------------------------------------------
module pb_capture_ctrl
    import pb_pkg::*;
#(
    parameter int unsigned WIN = DefWin,
    parameter int unsigned CW  = DefCw
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    pb_capture_ctrl_if.slave     bus
);

    localparam int unsigned  RW       = $clog2(WIN);
    localparam int unsigned  CntW     = $clog2(take_total(WIN) + 1);
    localparam logic [CntW-1:0] LastTake = CntW'(take_total(WIN) - 1);

    cap_state_e     state_q;
    logic [CW-1:0]  win_x_q, win_y_q;
    logic [CntW-1:0] cnt_q;
    logic           take_q;
    logic [RW-1:0]  row_q, col_q;
    logic           overrun_q;

    logic           hit;
    logic [RW-1:0]  hit_row, hit_col;
    logic           capturing;
    logic [CntW-1:0] cnt_base;
    logic           take_d;
    logic           done_d;

    pb_win_hit #(
        .WIN (WIN),
        .CW  (CW)
    ) u_win_hit (
        .i_pix_valid (bus.i_pix_valid),
        .i_x         (bus.i_x),
        .i_y         (bus.i_y),
        .i_win_x     (win_x_q),
        .i_win_y     (win_y_q),
        .o_hit       (hit),
        .o_row       (hit_row),
        .o_col       (hit_col)
    );

    always_comb begin
        // The frame-start cycle in ARMED already belongs to the captured frame.
        capturing = (state_q == StCapture) || ((state_q == StArmed) && bus.i_frame_start);
        // A frame start restarts counting, including the retry case.
        cnt_base  = bus.i_frame_start ? '0 : cnt_q;
        take_d    = capturing && hit;
        done_d    = take_d && (cnt_base == LastTake);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= StIdle;
            win_x_q   <= '0;
            win_y_q   <= '0;
            cnt_q     <= '0;
            take_q    <= 1'b0;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
        end else begin
            take_q    <= take_d;
            overrun_q <= 1'b0;

            if (take_d) begin
                row_q <= hit_row;
                col_q <= hit_col;
            end

            if (capturing) begin
                if (done_d) begin
                    cnt_q <= '0;
                end else if (take_d) begin
                    cnt_q <= cnt_base + CntW'(1);
                end else begin
                    cnt_q <= cnt_base;
                end
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.i_arm) begin
                        win_x_q <= bus.i_win_x;
                        win_y_q <= bus.i_win_y;
                        state_q <= StArmed;
                    end
                end
                StArmed: begin
                    if (bus.i_frame_start) begin
                        state_q <= done_d ? StDone : StCapture;
                    end
                end
                StCapture: begin
                    if (bus.i_frame_start) begin
                        overrun_q <= 1'b1;
                    end
                    if (done_d) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    // Ack wins over a simultaneous arm; arm is only seen in IDLE.
                    if (bus.i_buf_ack) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.o_take      = take_q;
    assign bus.o_row       = row_q;
    assign bus.o_col       = col_q;
    assign bus.o_overrun   = overrun_q;
    assign bus.o_buf_valid = (state_q == StDone);
    assign bus.o_busy      = (state_q == StArmed) || (state_q == StCapture);

endmodule

// File: tb/tb_pb_capture_ctrl.sv
// ----------------------------------------------------------------------------
// tb_pb_capture_ctrl -- scoreboard bench for pb_capture_ctrl.
//
// The driver pushes the expected {row,col} of every pixel that should be
// taken; a monitor pops and compares on each o_take. Frames are streamed as
// a frame-start pixel at (0,0), a band of rows/columns around the window and
// the bottom-right corner (639,479) of a 640x480 raster.
// ----------------------------------------------------------------------------
module tb_pb_capture_ctrl;
    import pb_pkg::*;

    localparam int unsigned WIN = 16;
    localparam int unsigned CW  = 12;
    localparam int unsigned RW  = $clog2(WIN);

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pb_capture_ctrl_if #(.WIN(WIN), .CW(CW)) bus ();

    pb_capture_ctrl #(
        .WIN (WIN),
        .CW  (CW)
    ) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [2*RW-1:0] exp_q[$];
    int              takes_seen = 0;
    int              ovr_seen   = 0;
    logic [RW-1:0]   last_row   = '0;
    logic [RW-1:0]   last_col   = '0;

    // Reference model: 0 idle, 1 armed, 2 capture, 3 done.
    int m_state   = 0;
    int m_wx      = 0;
    int m_wy      = 0;
    int m_cnt     = 0;
    int m_ovr_exp = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic check_status(input string name);
        check({name, "_busy"}, int'(bus.o_busy), int'(m_state == 1 || m_state == 2));
        check({name, "_buf_valid"}, int'(bus.o_buf_valid), int'(m_state == 3));
    endtask

    function automatic bit inwin(input int x, input int y);
        return x >= m_wx && x < m_wx + int'(WIN) && y >= m_wy && y < m_wy + int'(WIN);
    endfunction

    // Monitor: compare every take against the scoreboard, count overruns.
    initial begin
        logic [2*RW-1:0] e;
        forever begin
            @(negedge clk);
            if (bus.o_overrun) ovr_seen++;
            if (bus.o_take) begin
                takes_seen++;
                last_row = bus.o_row;
                last_col = bus.o_col;
                check("take_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("take_row_col", int'({bus.o_row, bus.o_col}), int'(e));
                end
            end
        end
    end

    task automatic send_pix(input bit fs, input bit v, input int x, input int y);
        bus.i_frame_start = fs;
        bus.i_pix_valid   = v;
        bus.i_x           = CW'(x);
        bus.i_y           = CW'(y);
        if (fs) begin
            if (m_state == 2) begin
                m_ovr_exp++;
                m_cnt = 0;
            end else if (m_state == 1) begin
                m_state = 2;
                m_cnt   = 0;
            end
        end
        if (v && m_state == 2 && inwin(x, y)) begin
            exp_q.push_back({RW'(y - m_wy), RW'(x - m_wx)});
            m_cnt++;
            if (m_cnt == int'(WIN * WIN)) m_state = 3;
        end
        @(posedge clk);
        #1;
        bus.i_frame_start = 1'b0;
        bus.i_pix_valid   = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_pix(1'b0, 1'b0, 0, 0);
    endtask

    // stop_after < 0 streams the whole band; otherwise stop after that many
    // pixels inside the model window.
    task automatic send_frame(input int x0, input int x1, input int y0, input int y1,
                              input bit gaps, input int stop_after);
        int hits;
        hits = 0;
        send_pix(1'b1, 1'b1, 0, 0);
        for (int y = y0; y <= y1; y++) begin
            for (int x = x0; x <= x1; x++) begin
                if (stop_after >= 0 && hits == stop_after) begin
                    idle(3);
                    return;
                end
                // Invalid cycle carrying an in-window coordinate.
                if (gaps) send_pix(1'b0, 1'b0, m_wx + 1, m_wy + 1);
                if (inwin(x, y)) hits++;
                send_pix(1'b0, 1'b1, x, y);
            end
        end
        send_pix(1'b0, 1'b1, 639, 479);
        idle(3);
    endtask

    task automatic do_arm(input int wx, input int wy, input bit ack);
        bus.i_arm     = 1'b1;
        bus.i_buf_ack = ack;
        bus.i_win_x   = CW'(wx);
        bus.i_win_y   = CW'(wy);
        if (ack && m_state == 3) begin
            m_state = 0;
        end else if (m_state == 0) begin
            m_state = 1;
            m_wx    = wx;
            m_wy    = wy;
        end
        @(posedge clk);
        #1;
        bus.i_arm     = 1'b0;
        bus.i_buf_ack = 1'b0;
    endtask

    task automatic do_ack();
        bus.i_buf_ack = 1'b1;
        if (m_state == 3) m_state = 0;
        @(posedge clk);
        #1;
        bus.i_buf_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        m_state = 0;
        m_cnt   = 0;
    endtask

    task automatic check_zero_outputs(input string name);
        check({name, "_take"}, int'(bus.o_take), 0);
        check({name, "_row"}, int'(bus.o_row), 0);
        check({name, "_col"}, int'(bus.o_col), 0);
        check({name, "_buf_valid"}, int'(bus.o_buf_valid), 0);
        check({name, "_busy"}, int'(bus.o_busy), 0);
        check({name, "_overrun"}, int'(bus.o_overrun), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        int t0;
        int o0;

        rst               = 1'b1;
        bus.i_frame_start = 1'b0;
        bus.i_pix_valid   = 1'b0;
        bus.i_x           = '0;
        bus.i_y           = '0;
        bus.i_win_x       = '0;
        bus.i_win_y       = '0;
        bus.i_arm         = 1'b0;
        bus.i_buf_ack     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero_outputs("reset");
        rst = 1'b0;
        idle(2);

        // Full capture of window (100,50).
        do_arm(100, 50, 1'b0);
        check_status("a_armed");
        t0 = takes_seen;
        send_frame(96, 119, 48, 67, 1'b0, -1);
        check("a_take_count", takes_seen - t0, 256);
        check("a_last_row_col", int'({last_row, last_col}), 8'hFF);
        check("a_queue_empty", exp_q.size(), 0);
        check_status("a_done");
        do_ack();
        check("a_ack_buf_valid", int'(bus.o_buf_valid), 0);
        check_status("a_idle");

        // Window inputs change after arm; pixel strobe gapped.
        do_arm(100, 50, 1'b0);
        bus.i_win_x = '0;
        bus.i_win_y = '0;
        t0 = takes_seen;
        send_frame(96, 119, 48, 67, 1'b1, -1);
        check("b_take_count", takes_seen - t0, 256);
        check("b_last_row_col", int'({last_row, last_col}), 8'hFF);
        check_status("b_done");

        // Ack and arm together in DONE: ack honoured, arm ignored.
        do_arm(200, 200, 1'b1);
        check("d_busy", int'(bus.o_busy), 0);
        check("d_buf_valid", int'(bus.o_buf_valid), 0);
        do_arm(100, 50, 1'b0);
        check("d_rearm_busy", int'(bus.o_busy), 1);

        // Reset after 37 takes, then a clean capture.
        t0 = takes_seen;
        send_frame(96, 119, 48, 67, 1'b0, 37);
        check("e_partial_takes", takes_seen - t0, 37);
        o0 = ovr_seen;
        do_reset();
        check_zero_outputs("e_reset");
        idle(2);
        check("e_no_overrun", ovr_seen - o0, 0);
        do_arm(100, 50, 1'b0);
        t0 = takes_seen;
        send_frame(96, 119, 48, 67, 1'b0, -1);
        check("e_take_count", takes_seen - t0, 256);
        check_status("e_done");
        do_ack();

        // Window partly outside the frame: retries only, never completes.
        do_arm(630, 470, 1'b0);
        o0 = ovr_seen;
        t0 = takes_seen;
        send_frame(626, 639, 466, 479, 1'b0, -1);
        do_arm(100, 50, 1'b0);
        send_frame(626, 639, 466, 479, 1'b0, -1);
        send_frame(626, 639, 466, 479, 1'b0, -1);
        check("f_overruns", ovr_seen - o0, 2);
        check("f_overruns_model", ovr_seen - o0, m_ovr_exp);
        check("f_take_count", takes_seen - t0, 303);
        check("f_buf_valid", int'(bus.o_buf_valid), 0);
        check("f_busy", int'(bus.o_busy), 1);
        do_reset();
        idle(2);
        check("f_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
